// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver: captures a binary value, converts it
// to BCD with a serial double-dabble, and scans the result across the digits.
module seg_scan_driver #(
  parameter int SCAN_DIV   = 4,
  parameter int BLANK_LEAD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digit,
  input  logic        load,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state, state_nxt;
  logic          accept, done;
  logic [13:0]   bin;
  logic [15:0]   bcd, bcd_adj, bcd_nxt, disp;
  logic [3:0]    iter;
  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic          wrap;
  logic [3:0]    nib;
  logic          blank1, blank2, blank3, blank_cur;
  logic [7:0]    seg_d;
  logic [3:0]    an_d;

  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'd0:    enc = 8'h3F;
      4'd1:    enc = 8'h06;
      4'd2:    enc = 8'h5B;
      4'd3:    enc = 8'h4F;
      4'd4:    enc = 8'h66;
      4'd5:    enc = 8'h6D;
      4'd6:    enc = 8'h7D;
      4'd7:    enc = 8'h07;
      4'd8:    enc = 8'h7F;
      4'd9:    enc = 8'h6F;
      default: enc = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (load) begin
        accept    = 1'b1;
        state_nxt = CONV;
      end
      CONV: if (iter == 4'd0) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state == CONV);

  // Add-3 correction on every nibble before the shift brings in the next MSB.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_nxt = {bcd_adj[14:0], bin[13]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin  <= '0;
      bcd  <= '0;
      iter <= '0;
      ovf  <= 1'b0;
      disp <= '0;
    end else if (accept) begin
      if (digit > 32'd9999) begin
        bin <= 14'd9999;
        ovf <= 1'b1;
      end else begin
        bin <= digit[13:0];
        ovf <= 1'b0;
      end
      bcd  <= '0;
      iter <= 4'd13;
    end else if (state == CONV) begin
      bcd  <= bcd_nxt;
      bin  <= {bin[12:0], 1'b0};
      iter <= iter - 4'd1;
      if (done) disp <= bcd_nxt;
    end
  end

  assign wrap = (div == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (wrap) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  // A digit is blank only if it and every higher digit are zero.
  always_comb begin
    blank3 = (disp[15:12] == 4'd0);
    blank2 = blank3 && (disp[11:8] == 4'd0);
    blank1 = blank2 && (disp[7:4] == 4'd0);
    case (idx)
      2'd0:    begin nib = disp[3:0];   blank_cur = 1'b0;   end
      2'd1:    begin nib = disp[7:4];   blank_cur = blank1; end
      2'd2:    begin nib = disp[11:8];  blank_cur = blank2; end
      default: begin nib = disp[15:12]; blank_cur = blank3; end
    endcase
    seg_d = (blank_cur && (BLANK_LEAD != 0)) ? 8'h00 : enc(nib);
    an_d  = 4'b0001 << idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b0001;
      seg <= 8'h3F;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: two instances (blanking on / off) share
// the stimulus; expected segment patterns are hand-computed constants.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] digit;
  logic        load;
  logic        busy_a, ovf_a, busy_b, ovf_b;
  logic [3:0]  an_a, an_b;
  logic [7:0]  seg_a, seg_b;

  int n_total = 0;
  int n_bad   = 0;
  int nb;

  seg_scan_driver #(.SCAN_DIV(4), .BLANK_LEAD(1)) u_bl (
    .clk(clk), .rst(rst), .digit(digit), .load(load),
    .busy(busy_a), .ovf(ovf_a), .an(an_a), .seg(seg_a)
  );

  seg_scan_driver #(.SCAN_DIV(4), .BLANK_LEAD(0)) u_nb (
    .clk(clk), .rst(rst), .digit(digit), .load(load),
    .busy(busy_b), .ovf(ovf_b), .an(an_b), .seg(seg_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Load v; optionally strobe v2 on busy cycle again_at, or pulse rst on busy cycle rst_at.
  task automatic conv(input logic [31:0] v, input int again_at, input logic [31:0] v2,
                      input int rst_at, output int nbusy);
    @(negedge clk);
    digit = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    nbusy = 0;
    while (busy_a && nbusy < 40) begin
      nbusy++;
      if (nbusy == again_at) begin
        digit = v2;
        load  = 1'b1;
      end
      if (nbusy == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_an", {28'd0, an_a}, 32'h1);
        chk("rst_seg", {24'd0, seg_a}, 32'h3F);
        @(negedge clk);
        rst = 1'b0;
      end
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic check_scan(input string tag, input bit sel, input logic [7:0] s0,
                            input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] exp_seg [4];
    logic [3:0] prev, cur_an;
    bit found;
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    found = 1'b0;
    prev  = sel ? an_b : an_a;
    for (int i = 0; i < 32 && !found; i++) begin
      @(negedge clk);
      cur_an = sel ? an_b : an_a;
      if (prev == 4'b1000 && cur_an == 4'b0001) found = 1'b1;
      prev = cur_an;
    end
    chk({tag, "_sync"}, {31'd0, found}, 32'd1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (d != 0 || c != 0) @(negedge clk);
        chk($sformatf("%s_an%0d", tag, d), {28'd0, sel ? an_b : an_a}, 32'(4'b0001 << d));
        chk($sformatf("%s_seg%0d", tag, d), {24'd0, sel ? seg_b : seg_a}, {24'd0, exp_seg[d]});
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    digit = '0;
    repeat (3) @(negedge clk);
    chk("in_rst_an", {28'd0, an_a}, 32'h1);
    chk("in_rst_seg", {24'd0, seg_a}, 32'h3F);
    chk("in_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("in_rst_ovf", {31'd0, ovf_a}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_an", {28'd0, an_a}, 32'h1);
    chk("rel_seg", {24'd0, seg_a}, 32'h3F);
    repeat (4) @(negedge clk);
    chk("hold_an", {28'd0, an_a}, 32'h1);
    @(negedge clk);
    chk("adv_an", {28'd0, an_a}, 32'h2);
    chk("adv_seg_bl", {24'd0, seg_a}, 32'h00);
    chk("adv_seg_nb", {24'd0, seg_b}, 32'h3F);

    conv(32'd1234, 0, 0, 0, nb);
    chk("busy_1234", nb, 32'd14);
    chk("ovf_1234", {31'd0, ovf_a}, 32'd0);
    check_scan("d1234", 1'b0, 8'h66, 8'h4F, 8'h5B, 8'h06);

    conv(32'd12000, 0, 0, 0, nb);
    chk("ovf_12000", {31'd0, ovf_a}, 32'd1);
    check_scan("d12000", 1'b0, 8'h6F, 8'h6F, 8'h6F, 8'h6F);
    check_scan("d12000nb", 1'b1, 8'h6F, 8'h6F, 8'h6F, 8'h6F);

    conv(32'd5, 0, 0, 0, nb);
    chk("ovf_5", {31'd0, ovf_a}, 32'd0);
    check_scan("d5", 1'b0, 8'h6D, 8'h00, 8'h00, 8'h00);

    conv(32'd9999, 0, 0, 0, nb);
    chk("ovf_9999", {31'd0, ovf_a}, 32'd0);
    check_scan("d9999", 1'b0, 8'h6F, 8'h6F, 8'h6F, 8'h6F);

    conv(32'd10000, 0, 0, 0, nb);
    chk("ovf_10000", {31'd0, ovf_a}, 32'd1);

    conv(32'd1234, 5, 32'd5678, 0, nb);
    chk("busy_ign", nb, 32'd14);
    chk("ovf_ign", {31'd0, ovf_a}, 32'd0);
    check_scan("ign", 1'b0, 8'h66, 8'h4F, 8'h5B, 8'h06);

    conv(32'd7, 5, 32'd12000, 0, nb);
    chk("ovf_keep", {31'd0, ovf_a}, 32'd0);
    check_scan("d7bl", 1'b0, 8'h07, 8'h00, 8'h00, 8'h00);
    check_scan("d7nb", 1'b1, 8'h07, 8'h3F, 8'h3F, 8'h3F);

    conv(32'd4321, 0, 0, 7, nb);
    chk("abort_cyc", nb, 32'd7);
    repeat (20) @(negedge clk);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_ovf", {31'd0, ovf_a}, 32'd0);
    check_scan("abort", 1'b0, 8'h3F, 8'h00, 8'h00, 8'h00);
    check_scan("abortnb", 1'b1, 8'h3F, 8'h3F, 8'h3F, 8'h3F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
